// File: rtl/mc_control.sv
// mc_control: multi-cycle main control unit for the 32-bit datapath.
// Sequences instructions through FETCH/DECODE/execute/memory/writeback states
// and drives the ALU's op/binv/cin inputs directly (no separate ALU control).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   Op, Funct           - IR[31:26] opcode, IR[5:0] function field
//   Zero                - ALU zero flag, used combinationally in BRANCH
//   PCWrite/PCWriteCond/PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource - datapath selects/enables
//   AluOp, AluBinv, AluCin - ALU controls (AluOp 00 OR, 01 AND, 10 ADD)
//   Illegal             - one-cycle pulse on unsupported opcode or funct
//   State               - current state code, for debug
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] AluOp,
    output logic       AluBinv,
    output logic       AluCin,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    state_t state;
    state_t next_state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state and Moore output decode; reset forces every output low
    always_comb begin
        next_state  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        AluOp       = 2'b00;
        AluBinv     = 1'b0;
        AluCin      = 1'b0;
        Illegal     = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                AluOp      = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ALUSrcB = 2'b11;
                AluOp   = 2'b10;
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    default:      Illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                AluOp      = 2'b10;
                next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                AluOp      = 2'b10;
                next_state = S_RWB;
                case (Funct)
                    FN_ADD: ;
                    FN_SUB: begin
                        AluBinv = 1'b1;
                        AluCin  = 1'b1;
                    end
                    FN_AND: AluOp = 2'b01;
                    FN_OR:  AluOp = 2'b00;
                    default: begin
                        Illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                AluOp       = 2'b10;
                AluBinv     = 1'b1;
                AluCin      = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: next_state = S_FETCH;
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            AluOp       = 2'b00;
            AluBinv     = 1'b0;
            AluCin      = 1'b0;
            Illegal     = 1'b0;
        end
    end

    // PC enable follows Zero combinationally in BRANCH
    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign State = reset ? 4'd0 : 4'(state);

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed instruction sequences, with the
// expected output vector of every cycle queued at drive time and checked at
// the following falling edge.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_binv;
        logic       alu_cin;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, AluBinv, AluCin, Illegal;
    logic [1:0] ALUSrcB, PCSource, AluOp;
    logic [3:0] State;

    out_t  obs;
    out_t  exp_q[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    mc_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .AluOp(AluOp), .AluBinv(AluBinv), .AluCin(AluCin),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    always_comb obs = {State, PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite,
                       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                       PCSource, AluOp, AluBinv, AluCin, Illegal};

    // Expected outputs for state st; z = Zero in BRANCH, ill = Illegal pulse,
    // alu = {AluOp, AluBinv, AluCin} in EXEC
    function automatic out_t ex(input int st, input logic z = 1'b0,
                                input logic ill = 1'b0, input logic [3:0] alu = 4'b1000);
        out_t e = '0;
        e.state = 4'(st);
        case (st)
            0: begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.pc_en = 1;
                     e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            1: begin e.alu_src_b = 2'b11; e.alu_op = 2'b10; e.illegal = ill; end
            2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
            3: begin e.mem_read = 1; e.iord = 1; end
            4: begin e.reg_write = 1; e.mem_to_reg = 1; end
            5: begin e.mem_write = 1; e.iord = 1; end
            6: begin e.alu_src_a = 1; {e.alu_op, e.alu_binv, e.alu_cin} = alu;
                     e.illegal = ill; end
            7: begin e.reg_write = 1; e.reg_dst = 1; end
            8: begin e.alu_src_a = 1; e.alu_op = 2'b10; e.alu_binv = 1; e.alu_cin = 1;
                     e.pc_write_cond = 1; e.pc_source = 2'b01; e.pc_en = z; end
            9: begin e.pc_write = 1; e.pc_source = 2'b10; e.pc_en = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Queue the expectation for this cycle, check it at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input out_t e, input string tag);
        out_t  want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op = op; Funct = fn; Zero = z;
    endtask

    initial begin
        reset = 1'b1;
        instr(6'b100011, 6'b000000, 1'b0);

        // Reset held three cycles: everything low
        step('0, "reset0");
        step('0, "reset1");
        step('0, "reset2");
        reset = 1'b0;

        // lw: 0,1,2,3,4
        step(ex(0), "lw_fetch");
        step(ex(1), "lw_decode");
        step(ex(2), "lw_memadr");
        step(ex(3), "lw_memrd");
        step(ex(4), "lw_memwb");

        // R-format add, sub, and, or
        instr(6'b000000, 6'b100000, 1'b0);
        step(ex(0), "add_fetch");
        step(ex(1), "add_decode");
        step(ex(6, 0, 0, 4'b1000), "add_exec");
        step(ex(7), "add_rwb");
        instr(6'b000000, 6'b100010, 1'b0);
        step(ex(0), "sub_fetch");
        step(ex(1), "sub_decode");
        step(ex(6, 0, 0, 4'b1011), "sub_exec");
        step(ex(7), "sub_rwb");
        instr(6'b000000, 6'b100100, 1'b0);
        step(ex(0), "and_fetch");
        step(ex(1), "and_decode");
        step(ex(6, 0, 0, 4'b0100), "and_exec");
        step(ex(7), "and_rwb");
        instr(6'b000000, 6'b100101, 1'b0);
        step(ex(0), "or_fetch");
        step(ex(1), "or_decode");
        step(ex(6, 0, 0, 4'b0000), "or_exec");
        step(ex(7), "or_rwb");

        // beq taken, then not taken
        instr(6'b000100, 6'b000000, 1'b1);
        step(ex(0), "beq1_fetch");
        step(ex(1), "beq1_decode");
        step(ex(8, 1), "beq1_branch");
        instr(6'b000100, 6'b000000, 1'b0);
        step(ex(0), "beq0_fetch");
        step(ex(1), "beq0_decode");
        step(ex(8, 0), "beq0_branch");

        // sw then j
        instr(6'b101011, 6'b000000, 1'b0);
        step(ex(0), "sw_fetch");
        step(ex(1), "sw_decode");
        step(ex(2), "sw_memadr");
        step(ex(5), "sw_memwr");
        instr(6'b000010, 6'b000000, 1'b0);
        step(ex(0), "j_fetch");
        step(ex(1), "j_decode");
        step(ex(9), "j_jump");

        // Illegal opcode, then illegal funct
        instr(6'b111111, 6'b000000, 1'b0);
        step(ex(0), "badop_fetch");
        step(ex(1, 0, 1), "badop_decode");
        instr(6'b000000, 6'b000000, 1'b0);
        step(ex(0), "badfn_fetch");
        step(ex(1), "badfn_decode");
        step(ex(6, 0, 1, 4'b1000), "badfn_exec");

        // Reset asserted in MEMWR, then resume with j
        instr(6'b101011, 6'b000000, 1'b0);
        step(ex(0), "swr_fetch");
        step(ex(1), "swr_decode");
        step(ex(2), "swr_memadr");
        reset = 1'b1;
        step('0, "swr_reset_memwr");
        step('0, "swr_reset_hold");
        reset = 1'b0;
        instr(6'b000010, 6'b000000, 1'b0);
        step(ex(0), "resume_fetch");
        step(ex(1), "resume_decode");
        step(ex(9), "resume_jump");
        step(ex(0), "final_fetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control unit for the 32-bit datapath. It sits directly upstream of the 32-bit ALU and the datapath muxes. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the ALU's `op[1:0]`/`binv`/`cin` inputs directly, so no separate ALU-control stage exists. Supported instructions: R-format (add, sub, and, or), lw, sw, beq and j.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `Op`  in  6  instruction opcode, `IR[31:26]`; valid from the Decode state onward.
- `Funct`  in  6  instruction `IR[5:0]`; used only for R-format.
- `Zero`  in  1  ALU result equals zero; sampled combinationally in the Branch state.
- `PCWrite`, `PCWriteCond`, `PCEn`  out  1 each  `PCEn = PCWrite | (PCWriteCond & Zero)`.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath mux selects and enables.
- `ALUSrcB`  out  2  selects B, 4, sign-extended immediate, or shifted sign-extended immediate.
- `PCSource`  out  2  selects ALU result, ALUOut, or jump target.
- `AluOp`  out  2  ALU mux select: 00 OR, 01 AND, 10 ADD.
- `AluBinv`, `AluCin`  out  1 each  set both to 1 for subtract.
- `Illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `State`  out  4  current state encoding, for debug.

## Operation
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BRANCH, 9 JUMP.
  - Codes 10-15 are unreachable; if entered, the next state is FETCH.
- Outputs are Moore, decoded from the state register. `AluOp`/`AluBinv`/`AluCin` in EXEC also depend on `Funct`.
- Any output not listed for a state is 0.
- FETCH:
  - Asserts: MemRead, IRWrite, PCWrite.
  - Selects: ALUSrcA=0, ALUSrcB=01, ADD (10/0/0), PCSource=00.
  - Next state: DECODE.
- DECODE:
  - Selects: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut).
  - Next state by `Op`: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 000010 → JUMP.
  - Any other `Op`: assert `Illegal`, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Next state MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALU controls decoded from `Funct`:
  - 100000 → ADD (10/0/0).
  - 100010 → SUB (10/1/1).
  - 100100 → AND (01/0/0).
  - 100101 → OR (00/0/0).
  - Any other `Funct`: ADD is driven, `Illegal` pulses, next state FETCH, and no RWB occurs.
  - Valid funct: next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB (10/1/1), PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.

## Timing
- Reset:
  - When `reset`=1 at a rising edge, the state becomes FETCH.
  - While `reset` is high, every output is forced to 0, including `PCEn`, `Illegal` and the `State` output (which reads 0).
  - The first active FETCH is the first cycle with `reset`=0.
- Reset mid-instruction: at the next edge the state returns to FETCH. No further RegWrite or MemWrite occurs for that instruction.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - R-format 4, lw 5, sw 4, beq 3, j 3.
  - Illegal opcode 2; illegal funct 3.
- `Illegal` is high for exactly one cycle: DECODE for a bad opcode, EXEC for a bad funct.
- `PCEn` is combinational in the same cycle. In BRANCH it follows `Zero` directly.

## Test plan
- Reset held for 3 cycles, then `Op`=100011 (lw): during reset all outputs are 0. After release, `State` sequence is 0,1,2,3,4,0. `RegWrite`=`MemtoReg`=1 only in state 4.
- R-format with `Funct` = 100010, then 100100, then 100101: in EXEC, `{AluOp,AluBinv,AluCin}` = {10,1,1}, {01,0,0}, {00,0,0} respectively. RWB asserts `RegDst`=`RegWrite`=1.
- beq with `Zero`=1, then `Zero`=0: `PCEn` is 1 and 0 respectively in state 8. Both take 3 cycles.
- sw, then j: sw `State` is 0,1,2,5,0 with `MemWrite`=1 only in state 5. j is 0,1,9,0 with `PCSource`=10 and `PCEn`=1 in state 9.
- `Op`=111111: `Illegal`=1 for one cycle in DECODE, then FETCH. R-format with `Funct`=000000: `Illegal` pulses in EXEC, `RegWrite` is never asserted.
- `reset` asserted during MEMWR: `MemWrite` drops to 0 that cycle. State is FETCH after the edge; the normal sequence resumes after release.
